// File: rtl/zacore_mem_bridge.sv
// zacore_mem_bridge: serialises zacore fetch/load/store requests onto one 1-cycle-latency SRAM
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_fetch_req, i_fetch_addr            instruction fetch request and byte address
//   i_read_req, i_write_req              load / store request (both high = store)
//   i_data_addr, i_data_write,
//   i_data_write_mask                    load/store byte address, store data, byte enables
//   o_inst_read, o_inst_valid            fetched word (held) and completion pulse
//   o_data_read, o_data_valid            loaded word (held) and load/store completion pulse
//   o_access_fault                       pulses with the valid of an out-of-window access
//   o_mem_en, o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata             single-port SRAM interface
// ADDR_WIDTH may be at most 30 so the window fits in the 32-bit address space.
module zacore_mem_bridge #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_req,
  input  logic                  i_read_req,
  input  logic                  i_write_req,
  input  logic [31:0]           i_fetch_addr,
  input  logic [31:0]           i_data_addr,
  input  logic [31:0]           i_data_write,
  input  logic [3:0]            i_data_write_mask,
  output logic [31:0]           o_inst_read,
  output logic                  o_inst_valid,
  output logic [31:0]           o_data_read,
  output logic                  o_data_valid,
  output logic                  o_access_fault,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, DATA_RSP, FETCH_RSP} state_t;
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;
  state_t      state_q, state_d;
  logic        fault_q, fault_d, wr_q, wr_d;
  logic [31:0] inst_q, data_q, rsp_data, addr, off;
  logic        data_go, fetch_go, in_win, go, rsp;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
      wr_q    <= 1'b0;
      inst_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wr_q    <= wr_d;
      if (state_q == FETCH_RSP) inst_q <= rsp_data;
      if (state_q == DATA_RSP && !wr_q) data_q <= rsp_data;
    end
  end
  // Data has priority, but each side is blocked while its own response is pending,
  // which lets a waiting fetch slip in during a data response and vice versa.
  // Subtracting the base first makes addresses below it wrap high, so one compare covers both bounds.
  always_comb begin
    data_go  = (i_read_req | i_write_req) && state_q != DATA_RSP;
    fetch_go = i_fetch_req && state_q != FETCH_RSP && !data_go;
    addr     = data_go ? i_data_addr : i_fetch_addr;
    off      = addr - BASE_ADDR;
    in_win   = {1'b0, off} < WIN_BYTES;
    state_d  = data_go ? DATA_RSP : fetch_go ? FETCH_RSP : IDLE;
    fault_d  = (data_go | fetch_go) && !in_win;
    wr_d     = data_go && i_write_req;
  end
  // Response data is forwarded straight from the SRAM in the response cycle and
  // captured into the hold registers at the end of it.
  always_comb begin
    go             = (data_go | fetch_go) && in_win && i_rst_n;
    o_mem_en       = go;
    o_mem_we       = (go && wr_d) ? i_data_write_mask : 4'b0000;
    o_mem_addr     = go ? off[ADDR_WIDTH+1:2] : '0;
    o_mem_wdata    = (go && wr_d) ? i_data_write : '0;
    rsp            = state_q != IDLE && i_rst_n;
    rsp_data       = fault_q ? 32'h0 : i_mem_rdata;
    o_inst_valid   = rsp && state_q == FETCH_RSP;
    o_data_valid   = rsp && state_q == DATA_RSP;
    o_access_fault = rsp && fault_q;
    o_inst_read    = o_inst_valid ? rsp_data : inst_q;
    o_data_read    = (o_data_valid && !wr_q) ? rsp_data : data_q;
  end
endmodule

// File: tb/tb_zacore_mem_bridge.sv
// tb_zacore_mem_bridge: directed self-checking bench with a behavioural 1-cycle SRAM
module tb_zacore_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, read_req, write_req;
  logic [31:0] fetch_addr, data_addr, data_write;
  logic [3:0]  mask;
  logic [31:0] inst_read, data_read, mem_wdata, mem_rdata;
  logic        inst_valid, data_valid, fault, mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] sram [0:16383];
  int checks = 0;
  int errors = 0;

  zacore_mem_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_req(fetch_req), .i_read_req(read_req), .i_write_req(write_req),
    .i_fetch_addr(fetch_addr), .i_data_addr(data_addr),
    .i_data_write(data_write), .i_data_write_mask(mask),
    .o_inst_read(inst_read), .o_inst_valid(inst_valid),
    .o_data_read(data_read), .o_data_valid(data_valid),
    .o_access_fault(fault),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
    sram[0]     = 32'h0123_4567;
    sram[1]     = 32'hDEAD_BEEF;
    sram[2]     = 32'hCAFE_F00D;
    sram[16383] = 32'hA5A5_A5A5;
    mem_rdata = 32'h0;
    rst_n = 1'b0; fetch_req = 0; read_req = 0; write_req = 0;
    fetch_addr = 0; data_addr = 0; data_write = 0; mask = 0;
    tick; tick;
    samp;
    chk("rst inst_read", inst_read, 32'h0);
    chk("rst data_read", data_read, 32'h0);
    chk("rst valids", {30'h0, inst_valid, data_valid}, 32'h0);
    chk("rst fault", {31'h0, fault}, 32'h0);
    chk("rst mem", {27'h0, mem_en, mem_we}, 32'h0);
    tick; rst_n = 1'b1;

    // fetch 0x4
    fetch_req = 1; fetch_addr = 32'h4;
    samp;
    chk("f4 issue en/we", {27'h0, mem_en, mem_we}, 32'h10);
    chk("f4 issue addr", {18'h0, mem_addr}, 32'h1);
    tick; samp;
    chk("f4 valid", {30'h0, inst_valid, data_valid}, 32'h2);
    chk("f4 inst_read", inst_read, 32'hDEAD_BEEF);
    chk("f4 no reissue", {31'h0, mem_en}, 32'h0);
    tick; fetch_req = 0;
    samp;
    chk("f4 pulse ends", {31'h0, inst_valid}, 32'h0);
    chk("f4 held", inst_read, 32'hDEAD_BEEF);

    // fetch 0x0 and read 0x8 together
    tick; fetch_req = 1; fetch_addr = 32'h0; read_req = 1; data_addr = 32'h8;
    samp;
    chk("both N addr", {18'h0, mem_addr}, 32'h2);
    chk("both N en", {31'h0, mem_en}, 32'h1);
    tick; samp;
    chk("both N+1 valids", {30'h0, inst_valid, data_valid}, 32'h1);
    chk("both N+1 data", data_read, 32'hCAFE_F00D);
    chk("both N+1 fetch issue", {13'h0, mem_en, mem_addr}, 32'h4000);
    tick; read_req = 0;
    samp;
    chk("both N+2 valids", {30'h0, inst_valid, data_valid}, 32'h2);
    chk("both N+2 inst", inst_read, 32'h0123_4567);
    tick; fetch_req = 0;
    samp;
    chk("both held inst", inst_read, 32'h0123_4567);
    chk("both held data", data_read, 32'hCAFE_F00D);

    // masked write then readback
    tick; write_req = 1; data_addr = 32'h10; data_write = 32'h1122_3344; mask = 4'b0101;
    samp;
    chk("wr we", {27'h0, mem_en, mem_we}, 32'h15);
    chk("wr addr", {18'h0, mem_addr}, 32'h4);
    chk("wr wdata", mem_wdata, 32'h1122_3344);
    tick; samp;
    chk("wr valid", {30'h0, inst_valid, data_valid}, 32'h1);
    chk("wr data_read kept", data_read, 32'hCAFE_F00D);
    tick; write_req = 0; read_req = 1;
    samp;
    chk("rb issue", {27'h0, mem_en, mem_we}, 32'h10);
    tick; samp;
    chk("rb data", data_read, 32'h0022_0044);
    tick; read_req = 0;

    // top word of the window, then first byte past it
    read_req = 1; data_addr = 32'h0000_FFFC;
    samp;
    chk("top issue", {13'h0, mem_en, mem_addr}, 32'h7FFF);
    tick; samp;
    chk("top data", data_read, 32'hA5A5_A5A5);
    chk("top no fault", {31'h0, fault}, 32'h0);
    tick; data_addr = 32'h0001_0000;
    samp;
    chk("oow en", {31'h0, mem_en}, 32'h0);
    tick; samp;
    chk("oow valid+fault", {30'h0, data_valid, fault}, 32'h3);
    chk("oow data", data_read, 32'h0);
    tick; read_req = 0;
    samp;
    chk("oow fault ends", {31'h0, fault}, 32'h0);

    // store with empty mask
    tick; write_req = 1; data_addr = 32'h10; data_write = 32'hFFFF_FFFF; mask = 4'b0000;
    samp;
    chk("m0 en/we", {27'h0, mem_en, mem_we}, 32'h10);
    tick; samp;
    chk("m0 valid", {31'h0, data_valid}, 32'h1);
    chk("m0 data kept", data_read, 32'h0);
    tick; write_req = 0; read_req = 1;
    tick; samp;
    chk("m0 readback", data_read, 32'h0022_0044);
    tick; read_req = 0;

    // reset while the data response is pending
    read_req = 1; data_addr = 32'h4;
    tick; rst_n = 1'b0;
    samp;
    chk("rstp no valid", {30'h0, inst_valid, data_valid}, 32'h0);
    tick; rst_n = 1'b1; read_req = 0;
    samp;
    chk("rstp data_read", data_read, 32'h0);
    chk("rstp inst_read", inst_read, 32'h0);
    chk("rstp quiet", {26'h0, inst_valid, data_valid, fault, mem_en, 2'b00}, 32'h0);

    // held fetch: issue on even cycles, respond on odd
    tick; fetch_req = 1; fetch_addr = 32'h4;
    for (int k = 0; k < 8; k++) begin
      samp;
      chk($sformatf("held c%0d en", k), {31'h0, mem_en}, {31'h0, k % 2 == 0});
      chk($sformatf("held c%0d valid", k), {31'h0, inst_valid}, {31'h0, k % 2 == 1});
      tick;
    end
    fetch_req = 0;
    samp;
    chk("held inst", inst_read, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
